// File: rtl/shiftreg_ctrl.sv
// Round-robin arbiter and frame sequencer for a parallel-load serial shift register.
// Grants one WIDTH-bit word per frame, times the shift-out, then idles for GAP cycles.
module shiftreg_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             shift_load,
  output logic [WIDTH-1:0] datain,
  output logic             frame_valid,
  output logic             done,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam int unsigned GapW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GapLast = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             ptr_q, ptr_d;  // 1: requester 1 wins a tie
  logic [WIDTH-1:0] datain_q, datain_d;
  logic             grant_q, grant_d;
  logic             pick1;

  assign pick1 = req1 & (~req0 | ptr_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_d       = ptr_q;
    datain_d    = datain_q;
    grant_d     = grant_q;
    shift_load  = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    frame_valid = 1'b0;
    done        = 1'b0;
    busy        = (state_q != StIdle);
    grant_id    = grant_q;
    datain      = datain_q;

    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d  = pick1;
          ptr_d    = ~pick1;
          datain_d = pick1 ? data1 : data0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        shift_load = 1'b1;
        ack0       = ~grant_q;
        ack1       = grant_q;
        bit_cnt_d  = CntW'(WIDTH - 1);
        state_d    = StShift;
      end
      StShift: begin
        frame_valid = 1'b1;
        if (bit_cnt_q == '0) begin
          done = 1'b1;
          if (GAP > 0) begin
            gap_cnt_d = GapW'(GapLast);
            state_d   = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ptr_q     <= 1'b0;
      datain_q  <= '0;
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ptr_q     <= ptr_d;
      datain_q  <= datain_d;
      grant_q   <= grant_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Bench for shiftreg_ctrl: frame-offset reference model, grant table, directed corner cases
// and randomized requesters; a second instance covers WIDTH=4, GAP=0.
module tb_shiftreg_ctrl;

  localparam int W      = 8;
  localparam int G      = 2;
  localparam int PERIOD = W + G + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         ack0, ack1, shift_load, frame_valid, done, busy, grant_id;
  logic [W-1:0] datain;

  logic         req0_b = 1'b0;
  logic [3:0]   data0_b = 4'h9, data1_b = 4'h6;
  logic         ack0_b, ack1_b, shift_load_b, frame_valid_b, done_b, busy_b, grant_id_b;
  logic [3:0]   datain_b;

  always #5 clk = ~clk;

  shiftreg_ctrl #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .shift_load(shift_load), .datain(datain), .frame_valid(frame_valid),
    .done(done), .busy(busy), .grant_id(grant_id)
  );

  shiftreg_ctrl #(.WIDTH(4), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .data0(data0_b), .ack0(ack0_b),
    .req1(1'b0), .data1(data1_b), .ack1(ack1_b),
    .shift_load(shift_load_b), .datain(datain_b), .frame_valid(frame_valid_b),
    .done(done_b), .busy(busy_b), .grant_id(grant_id_b)
  );

  // Behavioural shift register with serial fill tied to 1.
  logic [W-1:0] sr = '0;
  logic         sout;
  always @(posedge clk) sr <= shift_load ? datain : {sr[W-2:0], 1'b1};
  assign sout = sr[W-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel_cyc;

  // Reference model: mk = cycles since the grant edge (0 = LOAD), -1 when idle.
  int           mk;
  logic [W-1:0] mword;
  logic         mgid, mfav;
  logic         obs_ack0 = 1'b0, obs_ack1 = 1'b0;

  int ack_cyc[8];
  int ack_id[8];
  int n_acks;

  typedef struct {
    logic r0, r1;
    logic [W-1:0] d0, d1;
    logic a0, a1, gid;
    logic [W-1:0] din;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mk = -1; mword = '0; mgid = 1'b0; mfav = 1'b0;
  endtask

  task automatic model_advance();
    logic win;
    if (!rst_n) begin
      model_reset();
    end else if (mk < 0) begin
      if (req0 || req1) begin
        win   = (req0 && req1) ? mfav : req1;
        mgid  = win;
        mword = win ? data1 : data0;
        mfav  = !win;
        mk    = 0;
      end
    end else begin
      mk++;
      if (mk > W + G) mk = -1;
    end
  endtask

  task automatic check_cycle();
    logic act;
    act = (mk >= 0);
    chk("ack0", ack0, act && mk == 0 && !mgid);
    chk("ack1", ack1, act && mk == 0 && mgid);
    chk("shift_load", shift_load, act && mk == 0);
    chk("frame_valid", frame_valid, act && mk >= 1 && mk <= W);
    chk("done", done, act && mk == W);
    chk("busy", busy, act);
    chk("grant_id", grant_id, mgid);
    chk("datain", datain, mword);
    if (act && mk >= 1 && mk <= W) chk("sout", sout, mword[W-mk]);
  endtask

  // Inputs change only at the negedge between steps; req drops on the ack cycle.
  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_cycle();
    obs_ack0 = ack0;
    obs_ack1 = ack1;
    if (ack0) req0 = 1'b0;
    if (ack1) req1 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    model_reset();
    step();
    step();
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mk != -1; i++) step();
    chk("drain_idle", busy, 1'b0);
  endtask

  task automatic run_stream(input logic en0, input logic en1, input int nfr);
    n_acks = 0;
    for (int i = 0; i < nfr * PERIOD + 20 && n_acks < nfr; i++) begin
      if (en0 && !obs_ack0) req0 = 1'b1;
      if (en1 && !obs_ack1) req1 = 1'b1;
      step();
      if (ack0 || ack1) begin
        ack_cyc[n_acks] = cyc;
        ack_id[n_acks]  = ack1;
        n_acks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("stream_frames", n_acks, nfr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] single_exp;
    int a_first, a_late, nb, lowrun;
    int back[8];
    logic seen_frame;

    tbl[0] = '{1'b1, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[1] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44};
    tbl[2] = '{1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 1'b0, 8'h55};
    tbl[3] = '{1'b1, 1'b0, 8'h77, 8'h88, 1'b1, 1'b0, 1'b0, 8'h77};
    tbl[4] = '{1'b1, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b1, 1'b1, 8'hAA};
    tbl[5] = '{1'b0, 1'b1, 8'hBB, 8'hCC, 1'b0, 1'b1, 1'b1, 8'hCC};
    tbl[6] = '{1'b1, 1'b1, 8'hDD, 8'hEE, 1'b1, 1'b0, 1'b0, 8'hDD};

    do_reset();

    // Single frame: MSB first on sout, done on the last bit, idle by cycle 12.
    single_exp = 8'b11011000;
    data0 = single_exp;
    req0  = 1'b1;
    step();
    chk("single_ack0", ack0, 1'b1);
    got = '0;
    for (int i = 0; i < W; i++) begin
      step();
      got = {got[W-2:0], sout};
      if (i == W - 1) chk("single_done_last", done, 1'b1);
    end
    chk("single_sout", got, single_exp);
    for (int i = 0; i < G + 1; i++) step();
    chk("single_idle_c12", busy, 1'b0);

    // Grant table from a fresh pointer.
    do_reset();
    foreach (tbl[v]) begin
      data0 = tbl[v].d0;
      data1 = tbl[v].d1;
      req0  = tbl[v].r0;
      req1  = tbl[v].r1;
      step();
      chk("tbl_ack0", ack0, tbl[v].a0);
      chk("tbl_ack1", ack1, tbl[v].a1);
      chk("tbl_grant_id", grant_id, tbl[v].gid);
      chk("tbl_datain", datain, tbl[v].din);
      req0 = 1'b0;
      req1 = 1'b0;
      drain();
    end

    // Contention from reset: 0,1,0,1 at PERIOD spacing.
    do_reset();
    data0 = 8'hA5;
    data1 = 8'h3C;
    run_stream(1'b1, 1'b1, 4);
    chk("cont_first_latency", ack_cyc[0] - rel_cyc, 1);
    for (int i = 0; i < 4; i++) chk("cont_order", ack_id[i], i % 2);
    for (int i = 1; i < 4; i++) chk("cont_spacing", ack_cyc[i] - ack_cyc[i-1], PERIOD);
    drain();

    // Lone requester 1 is never blocked by the pointer.
    data1 = 8'h5C;
    run_stream(1'b0, 1'b1, 3);
    for (int i = 0; i < 3; i++) chk("stream1_id", ack_id[i], 1);
    for (int i = 1; i < 3; i++) chk("stream1_spacing", ack_cyc[i] - ack_cyc[i-1], PERIOD);
    drain();

    // Late request during SHIFT waits for the next IDLE.
    data0 = 8'h5A;
    req0  = 1'b1;
    step();
    a_first = cyc;
    for (int i = 0; i < 3; i++) step();
    data1 = 8'hC3;
    req1  = 1'b1;
    a_late = -1;
    for (int i = 0; i < 30 && a_late < 0; i++) begin
      step();
      if (ack1) a_late = cyc;
    end
    chk("late_ack1_spacing", a_late - a_first, PERIOD);
    drain();

    // Asynchronous reset in SHIFT cycle 3 of a requester-1 frame.
    data1 = 8'h96;
    req1  = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_shift_load", shift_load, 1'b0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_datain", datain, '0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    data0 = 8'h81;
    req0  = 1'b1;
    step();
    chk("post_rst_ack0", ack0, 1'b1);
    drain();

    // WIDTH=4, GAP=0 instance: period 6, frame_valid low for 2 cycles between frames.
    req0_b     = 1'b1;
    nb         = 0;
    lowrun     = 0;
    seen_frame = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack0_b && nb < 8) begin
        back[nb] = i;
        nb++;
      end
      if (frame_valid_b) begin
        if (seen_frame && lowrun > 0) chk("b_fv_low_run", lowrun, 2);
        seen_frame = 1'b1;
        lowrun     = 0;
      end else begin
        lowrun++;
      end
    end
    req0_b = 1'b0;
    chk("b_frames_seen", nb >= 5, 1'b1);
    for (int i = 1; i < 5; i++) chk("b_period", back[i] - back[i-1], 6);

    // Randomized requesters against the reference model.
    for (int i = 0; i < 800; i++) begin
      if (!req0 && !obs_ack0 && $urandom_range(3) == 0) begin
        req0  = 1'b1;
        data0 = W'($urandom);
      end
      if (!req1 && !obs_ack1 && $urandom_range(3) == 0) begin
        req1  = 1'b1;
        data1 = W'($urandom);
      end
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
